// File: rtl/shared_memory_banked_v2.sv
// Banked warp-wide shared memory: lanes arbitrate onto NUM_BANKS single-port word banks, conflicts serialised.
// Optional macro SMEM_BROADCAST_EN: same-word read lanes on a bank are served together in one cycle.
module shared_memory_banked_v2 #(
    parameter int LANES      = 32,
    parameter int NUM_BANKS  = 8,
    parameter int SMEM_BYTES = 4096,
    parameter int ADDR_W     = 32,
    parameter int WARP_ID_W  = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write_en,
    input  logic [WARP_ID_W-1:0]             req_warp_id,
    input  logic [LANES-1:0]                 req_thread_mask,
    input  logic [LANES-1:0][ADDR_W-1:0]     req_address,
    input  logic [LANES-1:0][31:0]           req_write_data,
    input  logic [LANES-1:0][3:0]            req_byte_enable,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [LANES-1:0][31:0]           resp_read_data,
    output logic [LANES-1:0]                 resp_thread_mask,
    output logic [WARP_ID_W-1:0]             resp_warp_id,
    output logic [31:0]                      bank_conflict_count,
    output logic [31:0]                      access_count,
    output logic [1:0]                       dbg_state
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = SMEM_BYTES / (4 * NUM_BANKS);
    localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Handshake: a request moves on req_valid && req_ready (req_ready only in IDLE);
    // a response moves on resp_valid && resp_ready, with all resp_* outputs held until then.
    state_t                         state_q;
    logic                           req_ready_q;
    logic                           resp_valid_q;
    logic                           write_q;
    logic [WARP_ID_W-1:0]           warp_q;
    logic [LANES-1:0]               mask_q;
    logic [LANES-1:0]               pending_q;
    logic [LANES-1:0]               land_q;
    logic [LANES-1:0][BANK_W-1:0]   bank_q;
    logic [LANES-1:0][ROW_W-1:0]    row_q;
    logic [LANES-1:0][31:0]         wdata_q;
    logic [LANES-1:0][3:0]          be_q;
    logic [LANES-1:0][31:0]         result_q;
    logic [31:0]                    conflict_q;
    logic [31:0]                    access_q;
    logic [31:0]                    cycles_q;

    logic                           serve_en;
    logic [NUM_BANKS-1:0]           grant_v;
    logic [NUM_BANKS-1:0][LANE_W-1:0] grant_lane;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  grant_row;
    logic [LANES-1:0]               served;
    logic [LANES-1:0]               pending_d;
    logic [NUM_BANKS-1:0][31:0]     bank_rdata;

    // Offset bits and bits above the capacity are deliberately dropped (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_address;

    assign serve_en = (state_q == S_SERVE);

    always_comb begin
        grant_v    = '0;
        grant_lane = '0;
        grant_row  = '0;
        served     = '0;
        // Scan downward so the lowest-index pending lane of each bank ends up granted.
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (pending_q[l] && bank_q[l] == BANK_W'(b)) begin
                    grant_v[b]    = 1'b1;
                    grant_lane[b] = LANE_W'(l);
                    grant_row[b]  = row_q[l];
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (pending_q[l]) begin
                if (grant_lane[bank_q[l]] == LANE_W'(l)) begin
                    served[l] = 1'b1;
                end
`ifdef SMEM_BROADCAST_EN
                else if (!write_q && grant_row[bank_q[l]] == row_q[l]) begin
                    served[l] = 1'b1;
                end
`endif
            end
        end
        pending_d = pending_q & ~served;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] mem [DEPTH];
        logic [31:0] rdata_q;

        always_ff @(posedge clk) begin
            if (serve_en && grant_v[b]) begin
                if (write_q) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_q[grant_lane[b]][k]) begin
                            mem[grant_row[b]][8*k +: 8] <= wdata_q[grant_lane[b]][8*k +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem[grant_row[b]];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            write_q      <= 1'b0;
            warp_q       <= '0;
            mask_q       <= '0;
            pending_q    <= '0;
            land_q       <= '0;
            bank_q       <= '0;
            row_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            result_q     <= '0;
            conflict_q   <= '0;
            access_q     <= '0;
            cycles_q     <= '0;
        end else begin
            land_q <= '0;
            // Bank read data issued last cycle lands in the lanes it was fetched for.
            for (int l = 0; l < LANES; l++) begin
                if (land_q[l]) begin
                    result_q[l] <= bank_rdata[bank_q[l]];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write_en;
                        warp_q    <= req_warp_id;
                        mask_q    <= req_thread_mask;
                        pending_q <= req_thread_mask;
                        wdata_q   <= req_write_data;
                        be_q      <= req_byte_enable;
                        for (int l = 0; l < LANES; l++) begin
                            bank_q[l] <= req_address[l][2 +: BANK_W];
                            row_q[l]  <= req_address[l][2 + BANK_W +: ROW_W];
                        end
                        result_q    <= '0;
                        access_q    <= access_q + 32'd1;
                        cycles_q    <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    pending_q <= pending_d;
                    land_q    <= write_q ? '0 : served;
                    cycles_q  <= cycles_q + 32'd1;
                    if (pending_d == '0) begin
                        // cycles_q counts serve cycles before this one, i.e. D-1.
                        conflict_q <= conflict_q + cycles_q;
                        if (write_q) begin
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready           = req_ready_q;
    assign resp_valid          = resp_valid_q;
    assign resp_read_data      = result_q;
    assign resp_thread_mask    = mask_q;
    assign resp_warp_id        = warp_q;
    assign bank_conflict_count = conflict_q;
    assign access_count        = access_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_shared_memory_banked_v2.sv
// Directed bench for shared_memory_banked_v2: scoreboard queue of expected read responses plus latency/counter checks.
module tb_shared_memory_banked_v2;
  localparam int LANES = 32;
  localparam int AW    = 32;
  localparam int WW    = 6;
  localparam int DW    = LANES * 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write_en;
  logic [WW-1:0]             req_warp_id;
  logic [LANES-1:0]          req_thread_mask;
  logic [LANES-1:0][AW-1:0]  req_address;
  logic [LANES-1:0][31:0]    req_write_data;
  logic [LANES-1:0][3:0]     req_byte_enable;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [LANES-1:0][31:0]    resp_read_data;
  logic [LANES-1:0]          resp_thread_mask;
  logic [WW-1:0]             resp_warp_id;
  logic [31:0]               bank_conflict_count;
  logic [31:0]               access_count;
  logic [1:0]                dbg_state;

  shared_memory_banked_v2 dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write_en        (req_write_en),
    .req_warp_id         (req_warp_id),
    .req_thread_mask     (req_thread_mask),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .req_byte_enable     (req_byte_enable),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_read_data      (resp_read_data),
    .resp_thread_mask    (resp_thread_mask),
    .resp_warp_id        (resp_warp_id),
    .bank_conflict_count (bank_conflict_count),
    .access_count        (access_count),
    .dbg_state           (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0]    exp_q[$];
  logic [LANES-1:0] exp_mask_q[$];
  logic [WW-1:0]    exp_warp_q[$];
  logic [LANES-1:0][31:0] exp_v;
  int exp_access = 0;
  int exp_conflict = 0;
  logic [31:0] mix [4] = '{32'h333333CC, 32'h3333CC33, 32'h33CC3333, 32'hCC333333};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      for (int l = 0; l < LANES; l++) begin
        if (act[32*l +: 32] !== req[32*l +: 32]) begin
          $display("FAIL %s lane=%0d actual=0x%08h required=0x%08h (cycle %0d)",
                   name, l, act[32*l +: 32], req[32*l +: 32], cyc);
          break;
        end
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid required=no_response (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check_data("resp_data", resp_read_data, e);
        check("resp_mask", resp_thread_mask, exp_mask_q.pop_front());
        check("resp_warp", resp_warp_id, exp_warp_q.pop_front());
      end
    end
  end

  // driver: issue one request, check latency and counters; hold>0 stalls resp_ready that many cycles
  task automatic run_req(input string tag, input logic we, input logic [LANES-1:0] mask,
                         input logic [WW-1:0] warp, input int d, input int hold);
    int t0;
    int n;
    if (!we && hold > 0) begin
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    @(negedge clk);
    req_write_en = we;
    req_thread_mask = mask;
    req_warp_id = warp;
    req_valid = 1'b1;
    if (!we) begin
      exp_q.push_back(exp_v);
      exp_mask_q.push_back(mask);
      exp_warp_q.push_back(warp);
    end
    t0 = cyc + 1;
    exp_access++;
    exp_conflict += d - 1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_busy"}, req_ready, 1'b0);
    n = 0;
    while (!(we ? req_ready : resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, cyc - t0, we ? d : d + 1);
    if (!we && hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        req_valid = (i < 3);
        check({tag, "_hold_valid"}, resp_valid, 1'b1);
        check({tag, "_hold_ready"}, req_ready, 1'b0);
        check_data({tag, "_hold_data"}, resp_read_data, exp_v);
        @(negedge clk);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    if (!we) begin
      n = 0;
      while (!req_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_done"}, req_ready, 1'b1);
    end
    check({tag, "_access"}, access_count, exp_access);
    check({tag, "_conflicts"}, bank_conflict_count, exp_conflict);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d3;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write_en = 1'b0;
    req_warp_id = '0;
    req_thread_mask = '0;
    req_address = '0;
    req_write_data = '0;
    req_byte_enable = '0;
    resp_ready = 1'b1;
    exp_v = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check_data("rst_resp_data", resp_read_data, '0);
    check("rst_resp_mask", resp_thread_mask, 0);
    check("rst_warp", resp_warp_id, 0);
    check("rst_access", access_count, 0);
    check("rst_conflicts", bank_conflict_count, 0);
    rst = 1'b0;

    // 1: stride-4 bytes, four lanes per bank
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = i * 4;
      req_write_data[i] = 32'hA000_0000 + i;
      req_byte_enable[i] = 4'hF;
      exp_v[i] = 32'hA000_0000 + i;
    end
    run_req("t1_wr", 1'b1, '1, 6'd1, 4, 0);
    run_req("t1_rd", 1'b0, '1, 6'd2, 4, 0);

    // 2: every lane on bank 0
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = i * 32;
      req_write_data[i] = 32'hB000_0000 + i;
      exp_v[i] = 32'hB000_0000 + i;
    end
    run_req("t2_wr", 1'b1, '1, 6'd3, 32, 0);
    run_req("t2_rd", 1'b0, '1, 6'd4, 32, 0);

    // 3: all lanes read the same word (lane 2 of test 2 wrote it)
`ifdef SMEM_BROADCAST_EN
    d3 = 1;
`else
    d3 = 32;
`endif
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = 32'h40;
      exp_v[i] = 32'hB000_0002;
    end
    run_req("t3_rd", 1'b0, '1, 6'd5, d3, 0);

    // 4: same-word writes, highest lane wins
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = 32'h80;
      req_write_data[i] = i;
      exp_v[i] = 32'h0;
    end
    exp_v[0] = 32'h0000_001F;
    run_req("t4_wr", 1'b1, '1, 6'd6, 32, 0);
    run_req("t4_rd", 1'b0, 32'h1, 6'd7, 1, 0);

    // 5: byte enables, one byte then the complement; upper address bits must wrap
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = 32'h0001_0000 + i * 4;
      req_write_data[i] = 32'hCCCC_CCCC;
      req_byte_enable[i] = 4'(1 << (i % 4));
      exp_v[i] = mix[i % 4];
    end
    run_req("t5_wr1", 1'b1, '1, 6'd8, 4, 0);
    for (int i = 0; i < LANES; i++) begin
      req_address[i] = i * 4;
      req_write_data[i] = 32'h3333_3333;
      req_byte_enable[i] = ~(4'(1 << (i % 4)));
    end
    run_req("t5_wr2", 1'b1, '1, 6'd9, 4, 0);
    run_req("t5_rd", 1'b0, '1, 6'd10, 4, 0);

    // zero mask: no bank changes, empty response
    req_write_data = '0;
    run_req("z_wr", 1'b1, '0, 6'd11, 1, 0);
    exp_v = '0;
    run_req("z_rd", 1'b0, '0, 6'd12, 1, 0);

    // 6a: back-pressure on the response; stray req_valid must not be accepted
    for (int i = 0; i < LANES; i++) exp_v[i] = mix[i % 4];
    run_req("t6_hold", 1'b0, '1, 6'd13, 4, 10);

    // 6b: reset in the middle of a long SERVE
    for (int i = 0; i < LANES; i++) req_address[i] = i * 32;
    @(negedge clk);
    req_write_en = 1'b0;
    req_thread_mask = '1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_pre_rst_state", dbg_state, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_req_ready", req_ready, 1'b1);
    check("t6_rst_resp_valid", resp_valid, 1'b0);
    check("t6_rst_access", access_count, 0);
    check("t6_rst_conflicts", bank_conflict_count, 0);
    check("t6_rst_mask", resp_thread_mask, 0);
    check("t6_rst_state", dbg_state, 2'd0);
    repeat (40) @(negedge clk);
    check("t6_no_resp", resp_valid, 1'b0);
    exp_access = 0;
    exp_conflict = 0;

    // memory survives reset
    for (int i = 0; i < LANES; i++) exp_v[i] = 32'hB000_0000 + i;
    for (int i = 0; i < 4; i++) exp_v[i] = 32'h3333_33CC;
    exp_v[4] = 32'h0000_001F;
    run_req("t6_post_rd", 1'b0, '1, 6'd14, 32, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
